// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus arbiter and the address decoder:
// FSM state encoding, I/O device address window and requester port indices.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Device-address window occupied by I/O devices 11..13
    localparam logic [31:0] IO_FIRST_ADDR = 32'd11;
    localparam logic [31:0] IO_LAST_ADDR  = 32'd13;

    // Requester port indices
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Inclusive range test: both window edges count as I/O
    function automatic logic in_io_range(input logic [31:0] a,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input winner selection for the MMIO bus arbiter.
// Default: round-robin, the port that did not own the last access wins a tie.
// Build option ARB_FIXED_PRIO_EN: the CPU port always wins a tie.
module rr_arb2
    import mmio_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       win
);

`ifdef ARB_FIXED_PRIO_EN
    // Previous owner is irrelevant under fixed priority
    logic unused_last;
    assign unused_last = last;

    // CPU wins whenever it requests; DMA only when alone
    always_comb begin
        win = PORT_CPU;
        if (!req[PORT_CPU] && req[PORT_DMA]) win = PORT_DMA;
    end
`else
    // Tie goes to the port that is not the previous owner; a lone requester wins
    always_comb begin
        win = PORT_CPU;
        if (req[PORT_CPU] && req[PORT_DMA]) win = ~last;
        else if (req[PORT_DMA])              win = PORT_DMA;
    end
`endif

endmodule

// File: rtl/mmio_bus_arbiter.sv
// MMIO bus arbiter: shares the processor data bus between the CPU load/store
// unit (port 0) and the DMA engine (port 1). Each access is sequenced with a
// per-target wait count, issues a single write strobe on its last access
// cycle, and returns read data with a one-cycle done pulse.
// Build option ARB_FIXED_PRIO_EN selects fixed CPU priority (see rr_arb2).
module mmio_bus_arbiter
    import mmio_pkg::*;
#(
    parameter int          MEM_WAIT = 2,
    parameter int          IO_WAIT  = 4,
    parameter logic [31:0] IO_FIRST = IO_FIRST_ADDR,
    parameter logic [31:0] IO_LAST  = IO_LAST_ADDR,
    parameter int          WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_memwrite,
    input  logic [31:0] bus_rdata
);

    // Counter load values: the counter reaches zero on the final access cycle
    localparam logic [WAIT_W-1:0] MEM_CNT = WAIT_W'(MEM_WAIT - 1);
    localparam logic [WAIT_W-1:0] IO_CNT  = WAIT_W'(IO_WAIT - 1);
    localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

    state_t            state;
    logic [WAIT_W-1:0] cnt;
    logic              owner;
    logic              last;
    logic              lat_we;

    logic              win;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_we;
    logic [WAIT_W-1:0] sel_cnt;

    rr_arb2 u_arb (
        .req  (req),
        .last (last),
        .win  (win)
    );

    // Steer the winning port's request fields and derive its wait count
    always_comb begin
        sel_addr  = (win == PORT_DMA) ? addr1  : addr0;
        sel_wdata = (win == PORT_DMA) ? wdata1 : wdata0;
        sel_we    = we[win];
        sel_cnt   = in_io_range(sel_addr, IO_FIRST, IO_LAST) ? IO_CNT : MEM_CNT;
    end

    // Access sequencer: grant, timed access with write strobe, done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            owner        <= PORT_CPU;
            last         <= PORT_DMA;
            lat_we       <= 1'b0;
            gnt          <= 2'b00;
            done         <= 2'b00;
            rdata        <= '0;
            busy         <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_memwrite <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done         <= 2'b00;
                    bus_memwrite <= 1'b0;
                    if (|req) begin
                        owner     <= win;
                        lat_we    <= sel_we;
                        cnt       <= sel_cnt;
                        gnt       <= {win, ~win};
                        busy      <= 1'b1;
                        bus_addr  <= sel_addr;
                        bus_wdata <= sel_wdata;
                        // Single-cycle access: the strobe belongs to the first ACCESS cycle
                        bus_memwrite <= sel_we && (sel_cnt == '0);
                        state     <= ACCESS;
                    end else begin
                        gnt       <= 2'b00;
                        busy      <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        rdata        <= bus_rdata;
                        bus_memwrite <= 1'b0;
                        bus_addr     <= '0;
                        bus_wdata    <= '0;
                        done         <= {owner, ~owner};
                        state        <= DONE;
                    end else begin
                        cnt          <= cnt - CNT_ONE;
                        // Raise the strobe so it is visible during the final access cycle only
                        bus_memwrite <= lat_we && (cnt == CNT_ONE);
                    end
                end
                DONE: begin
                    done  <= 2'b00;
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                    last  <= owner;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Self-checking bench for mmio_bus_arbiter (default parameters).
module tb_mmio_bus_arbiter;

    localparam int MEM_WAIT = 2;
    localparam int IO_WAIT  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [31:0] bus_rdata = 32'h1;
    logic [1:0]  gnt, done;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic        busy, bus_memwrite;

    mmio_bus_arbiter #(.MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_memwrite(bus_memwrite), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wt;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    logic m_last;

    function automatic int exp_wait(input logic [31:0] a);
        return (a >= 32'd11 && a <= 32'd13) ? IO_WAIT : MEM_WAIT;
    endfunction

    function automatic logic pick(input logic [1:0] r, input logic l);
`ifdef ARB_FIXED_PRIO_EN
        if (r[0]) return 1'b0;
        return 1'b1;
`else
        if (r == 2'b11) return ~l;
        return r[1];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fail_now(input string tag);
        n_total++;
        $error("FAIL %s: observed timeout/empty expected event", tag);
    endtask

    task automatic push(input logic p);
        exp_t e;
        e.port  = p;
        e.we    = we[p];
        e.addr  = p ? addr1 : addr0;
        e.wdata = p ? wdata1 : wdata0;
        e.wt    = exp_wait(e.addr);
        sb.push_back(e);
    endtask

    // Advance one cycle, sample point 1 ns after the edge; bus_rdata changes every cycle
    task automatic tick;
        @(posedge clk);
        #1;
        bus_rdata = bus_rdata * 32'd1103515245 + 32'd12345;
    endtask

    task automatic observe(input string tag, input int drop_at, input bit drop_on_done);
        exp_t        e;
        int          cyc = 0, acc = 0, mw = 0, gidx = 0;
        bit          seen = 0, path_ok = 1;
        logic        mw_last = 1'b0;
        logic [31:0] last_rd = '0;
        logic [1:0]  oh;
        if (sb.size() == 0) begin
            fail_now({tag, "_sb_empty"});
            return;
        end
        e  = sb.pop_front();
        oh = e.port ? 2'b10 : 2'b01;
        while (cyc < 40) begin
            tick;
            cyc++;
            if (!seen && gnt !== 2'b00) begin
                seen = 1;
                gidx = cyc;
                chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
            end
            if (seen && busy === 1'b1 && done === 2'b00) begin
                acc++;
                if (bus_addr !== e.addr || bus_wdata !== e.wdata || gnt !== oh) path_ok = 0;
                if (bus_memwrite === 1'b1) mw++;
                mw_last = bus_memwrite;
                last_rd = bus_rdata;
                if (acc == drop_at) req[e.port] = 1'b0;
            end else if (done !== 2'b00) begin
                chk({tag, "_done"},     32'(done), 32'(oh));
                chk({tag, "_gnt_done"}, 32'(gnt), 32'(oh));
                chk({tag, "_rdata"},    rdata, last_rd);
                chk({tag, "_acc_cyc"},  32'(acc), 32'(e.wt));
                chk({tag, "_latency"},  32'(cyc - gidx), 32'(e.wt));
                chk({tag, "_mw_count"}, 32'(mw), 32'(e.we));
                chk({tag, "_mw_last"},  32'(mw_last), 32'(e.we));
                chk({tag, "_mw_done"},  32'(bus_memwrite), 32'd0);
                chk({tag, "_bus_path"}, 32'(path_ok), 32'd1);
                if (drop_on_done) req[e.port] = 1'b0;
                m_last = e.port;
                return;
            end
        end
        fail_now({tag, "_timeout"});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"},   32'(gnt), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_addr"},  bus_addr, 32'd0);
        chk({tag, "_wdata"}, bus_wdata, 32'd0);
        chk({tag, "_mw"},    32'(bus_memwrite), 32'd0);
    endtask

    logic [31:0] bounds [6];

    initial begin
        logic pl;
        logic p;
        bit   ok;
        int   n;

        bounds = '{32'd10, 32'd11, 32'd13, 32'd14, 32'd0, 32'hFFFF_FFFF};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset  = 1'b0;
        m_last = 1'b1;

        // Idle with no request keeps the bus quiet
        tick;
        tick;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_addr", bus_addr, 32'd0);

        // CPU read from memory
        addr0 = 32'd100; wdata0 = 32'hDEAD_0100; we = 2'b00; req = 2'b01;
        push(1'b0);
        observe("cpu_rd", -1, 1);

        // DMA write to I/O device 12
        addr1 = 32'd12; wdata1 = 32'hCAFE_0012; we = 2'b10; req = 2'b10;
        push(1'b1);
        observe("dma_wr", -1, 1);
        we = 2'b00;

        // Address window edges and extremes
        foreach (bounds[i]) begin
            addr0 = bounds[i]; wdata0 = 32'h5A00_0000 + 32'(i); req = 2'b01;
            push(1'b0);
            observe($sformatf("bound_%0h", bounds[i]), -1, 1);
        end

        // Both ports requesting continuously
        addr0 = 32'd10; wdata0 = 32'h1111_0000;
        addr1 = 32'd14; wdata1 = 32'h2222_0000;
        we = 2'b01; req = 2'b11;
        pl = m_last;
        for (int i = 0; i < 4; i++) begin
            p = pick(2'b11, pl);
            push(p);
            pl = p;
        end
        for (int i = 0; i < 4; i++) observe($sformatf("arb_%0d", i), -1, 0);
        req = 2'b00;
        we  = 2'b00;

        // CPU drops request after the first access cycle
        addr0 = 32'd100; wdata0 = 32'h3333_0000; req = 2'b01;
        push(1'b0);
        observe("cpu_drop", 1, 0);
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (busy !== 1'b0 || gnt !== 2'b00 || done !== 2'b00 || bus_addr !== 32'd0) ok = 0;
        end
        chk("drop_idle", 32'(ok), 32'd1);

        // Reset during the second access cycle of a DMA write to device 11
        addr1 = 32'd11; wdata1 = 32'h4444_0011; we = 2'b10; req = 2'b10;
        n = 0;
        while (gnt === 2'b00 && n < 10) begin
            tick;
            n++;
        end
        if (gnt === 2'b00) fail_now("midrst_gnt");
        else chk("midrst_gnt", 32'(gnt), 32'b10);
        tick;
        chk("midrst_pre_mw", 32'(bus_memwrite), 32'd0);
        reset = 1'b1;
        req   = 2'b00;
        we    = 2'b00;
        #1;
        check_reset_outputs("midrst");
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (bus_memwrite !== 1'b0 || done !== 2'b00 || busy !== 1'b0) ok = 0;
        end
        chk("midrst_quiet", 32'(ok), 32'd1);
        reset  = 1'b0;
        m_last = 1'b1;

        // First request after reset goes to the CPU
        addr0 = 32'd200; wdata0 = 32'h5555_0000;
        addr1 = 32'd300; wdata1 = 32'h6666_0000;
        req = 2'b11;
        push(pick(2'b11, m_last));
        observe("post_rst", -1, 1);
        req = 2'b00;
        tick;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
